// File: rtl/overcooked_pkg.sv
// Shared kitchen codes: player-state (P_*) and grid-object (G_*) encodings,
// grid dimensions, the stove FSM state type and small helpers.
package overcooked_pkg;

    localparam int GRID_H = 8;
    localparam int GRID_W = 13;

    localparam logic [3:0] P_NOTHING       = 4'd0;
    localparam logic [3:0] P_ONION_WHOLE   = 4'd1;
    localparam logic [3:0] P_ONION_CHOPPED = 4'd2;
    localparam logic [3:0] P_POT_EMPTY     = 4'd3;
    localparam logic [3:0] P_POT_RAW       = 4'd4;
    localparam logic [3:0] P_POT_COOKED    = 4'd5;
    localparam logic [3:0] P_BOWL_EMPTY    = 4'd6;
    localparam logic [3:0] P_BOWL_FULL     = 4'd7;
    localparam logic [3:0] P_EXT_OFF       = 4'd8;
    localparam logic [3:0] P_EXT_ON        = 4'd9;
    localparam logic [3:0] P_CHOPPING      = 4'd10;

    localparam logic [3:0] G_EMPTY         = 4'd0;
    localparam logic [3:0] G_ONION_WHOLE   = 4'd1;
    localparam logic [3:0] G_ONION_CHOPPED = 4'd2;
    localparam logic [3:0] G_BOWL_EMPTY    = 4'd3;
    localparam logic [3:0] G_BOWL_FULL     = 4'd4;
    localparam logic [3:0] G_POT_EMPTY     = 4'd5;
    localparam logic [3:0] G_POT_RAW       = 4'd6;
    localparam logic [3:0] G_POT_COOKED    = 4'd7;
    localparam logic [3:0] G_POT_FIRE      = 4'd8;
    localparam logic [3:0] G_FIRE          = 4'd9;
    localparam logic [3:0] G_EXTINGUISHER  = 4'd10;

    typedef logic [GRID_H-1:0][GRID_W-1:0][3:0] grid_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_BURNING = 2'd2
    } stove_state_e;

    function automatic logic is_carry(input logic [3:0] p);
        return (p >= P_ONION_WHOLE) && (p <= P_EXT_OFF);
    endfunction

    function automatic logic [3:0] state_to_grid(input logic [3:0] p);
        case (p)
            P_ONION_WHOLE:   return G_ONION_WHOLE;
            P_ONION_CHOPPED: return G_ONION_CHOPPED;
            P_POT_EMPTY:     return G_POT_EMPTY;
            P_POT_RAW:       return G_POT_RAW;
            P_POT_COOKED:    return G_POT_COOKED;
            P_BOWL_EMPTY:    return G_BOWL_EMPTY;
            P_BOWL_FULL:     return G_BOWL_FULL;
            P_EXT_OFF:       return G_EXTINGUISHER;
            default:         return G_EMPTY;
        endcase
    endfunction

    function automatic grid_t layout_grid(input logic [3:0] sx, input logic [2:0] sy);
        grid_t g;
        g = '0;
        g[sy][sx]  = G_POT_EMPTY;
        g[7][0]    = G_ONION_WHOLE;
        g[7][12]   = G_BOWL_EMPTY;
        g[0][12]   = G_EXTINGUISHER;
        return g;
    endfunction

endpackage

// File: rtl/grid_update_if.sv
// Bundle between the player-state logic and the grid updater.
interface grid_update_if;
    import overcooked_pkg::*;

    // frame_tick is a one-cycle strobe, not a handshake: the master holds
    // player_state/x_front/y_front stable in the strobe cycle, and the slave
    // consumes them on that edge only; there is no backpressure.
    logic         frame_tick;
    logic [3:0]   player_state;
    logic [3:0]   x_front;
    logic [2:0]   y_front;
    grid_t        object_grid;
    logic [9:0]   chop_count;
    logic [9:0]   cook_count;
    stove_state_e stove_state;

    modport master (
        output frame_tick, player_state, x_front, y_front,
        input  object_grid, chop_count, cook_count, stove_state
    );

    modport slave (
        input  frame_tick, player_state, x_front, y_front,
        output object_grid, chop_count, cook_count, stove_state
    );

endinterface

// File: rtl/cook_timer.sv
// Stove FSM: tracks what sits on the stove and times raw->cooked->fire.
module cook_timer
    import overcooked_pkg::*;
#(
    parameter int COOK_FRAMES = 300,
    parameter int BURN_FRAMES = 300
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic [3:0]   stove_cell,
    input  logic         player_wrote_stove,
    output logic         stove_write_en,
    output logic [3:0]   stove_write_val,
    output logic [9:0]   cook_count,
    output stove_state_e state_o
);

    stove_state_e state_q;
    stove_state_e mode;
    logic [9:0]   count_q;
    logic         limit_hit;

    always_comb begin
        mode = ST_IDLE;
        if (stove_cell == G_POT_RAW) begin
            mode = ST_COOKING;
        end else if (stove_cell == G_POT_COOKED) begin
            mode = ST_BURNING;
        end
        limit_hit = 1'b0;
        if (mode == ST_COOKING && count_q == 10'(COOK_FRAMES - 1)) limit_hit = 1'b1;
        if (mode == ST_BURNING && count_q == 10'(BURN_FRAMES - 1)) limit_hit = 1'b1;
        stove_write_en  = limit_hit;
        stove_write_val = (mode == ST_BURNING) ? G_POT_FIRE : G_POT_COOKED;
    end

    // A change of stove contents restarts the count, so a pot never inherits
    // progress from whatever was there before.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else if (frame_tick) begin
            state_q <= mode;
            if (player_wrote_stove || limit_hit || mode == ST_IDLE) begin
                count_q <= '0;
            end else if (mode != state_q) begin
                count_q <= 10'd1;
            end else begin
                count_q <= count_q + 10'd1;
            end
        end
    end

    assign cook_count = count_q;
    assign state_o    = state_q;

endmodule

// File: rtl/grid_update.sv
// Kitchen object grid: applies player pickups/drops/transfers, chopping and
// extinguishing once per frame, plus stove-driven cooking and burning.
module grid_update
    import overcooked_pkg::*;
#(
    parameter int CHOP_FRAMES = 120,
    parameter int COOK_FRAMES = 300,
    parameter int BURN_FRAMES = 300,
    parameter int STOVE_X     = 6,
    parameter int STOVE_Y     = 0
) (
    input logic          clk,
    input logic          reset,
    grid_update_if.slave bus
);

    localparam grid_t RESET_GRID = layout_grid(4'(STOVE_X), 3'(STOVE_Y));

    grid_t      grid_q, grid_d;
    logic [3:0] prev_state_q;
    logic [9:0] chop_q, chop_d;
    logic [3:0] prev_x_q;
    logic [2:0] prev_y_q;

    logic       front_valid, same_pos, chop_active, chop_done;
    logic [3:0] front_cell, cur;
    logic       pw_en, player_wrote_stove;
    logic [3:0] pw_val;
    logic       stove_we;
    logic [3:0] stove_val;

    always_comb begin
        cur         = bus.player_state;
        front_valid = (bus.x_front <= 4'd12);
        front_cell  = G_EMPTY;
        if (front_valid) front_cell = grid_q[bus.y_front][bus.x_front];
        same_pos    = (bus.x_front == prev_x_q) && (bus.y_front == prev_y_q);
        chop_active = (cur == P_CHOPPING) && front_valid &&
                      (front_cell == G_ONION_WHOLE) && same_pos;
        chop_done   = chop_active && (chop_q == 10'(CHOP_FRAMES - 1));
        chop_d      = chop_active ? (chop_done ? 10'd0 : chop_q + 10'd1) : 10'd0;

        // At most one player-driven write; the transitions are mutually exclusive.
        pw_en  = 1'b0;
        pw_val = G_EMPTY;
        if (front_valid) begin
            if (prev_state_q == P_NOTHING && is_carry(cur)) begin
                pw_en = 1'b1;
            end else if (is_carry(prev_state_q) && cur == P_NOTHING) begin
                if (front_cell == G_EMPTY) begin
                    pw_en  = 1'b1;
                    pw_val = state_to_grid(prev_state_q);
                end
            end else if (prev_state_q == P_POT_EMPTY && cur == P_POT_RAW &&
                         front_cell == G_ONION_CHOPPED) begin
                pw_en = 1'b1;
            end else if (prev_state_q == P_POT_COOKED && cur == P_POT_EMPTY &&
                         front_cell == G_BOWL_EMPTY) begin
                pw_en  = 1'b1;
                pw_val = G_BOWL_FULL;
            end else if (prev_state_q == P_BOWL_EMPTY && cur == P_BOWL_FULL &&
                         front_cell == G_POT_COOKED) begin
                pw_en  = 1'b1;
                pw_val = G_POT_EMPTY;
            end else if (cur == P_EXT_ON && front_cell == G_FIRE) begin
                pw_en = 1'b1;
            end else if (cur == P_EXT_ON && front_cell == G_POT_FIRE) begin
                pw_en  = 1'b1;
                pw_val = G_POT_EMPTY;
            end else if (chop_done) begin
                pw_en  = 1'b1;
                pw_val = G_ONION_CHOPPED;
            end
        end
        player_wrote_stove = pw_en && (bus.x_front == 4'(STOVE_X)) &&
                             (bus.y_front == 3'(STOVE_Y));

        // Player write is applied last so it wins a collision on the stove cell.
        grid_d = grid_q;
        if (stove_we) grid_d[STOVE_Y][STOVE_X] = stove_val;
        if (pw_en) grid_d[bus.y_front][bus.x_front] = pw_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q       <= RESET_GRID;
            prev_state_q <= P_NOTHING;
            chop_q       <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
        end else if (bus.frame_tick) begin
            grid_q       <= grid_d;
            prev_state_q <= cur;
            chop_q       <= chop_d;
            prev_x_q     <= bus.x_front;
            prev_y_q     <= bus.y_front;
        end
    end

    cook_timer #(
        .COOK_FRAMES(COOK_FRAMES),
        .BURN_FRAMES(BURN_FRAMES)
    ) u_cook_timer (
        .clk               (clk),
        .reset             (reset),
        .frame_tick        (bus.frame_tick),
        .stove_cell        (grid_q[STOVE_Y][STOVE_X]),
        .player_wrote_stove(player_wrote_stove),
        .stove_write_en    (stove_we),
        .stove_write_val   (stove_val),
        .cook_count        (bus.cook_count),
        .state_o           (bus.stove_state)
    );

    assign bus.object_grid = grid_q;
    assign bus.chop_count  = chop_q;

endmodule

// File: tb/tb_grid_update.sv
// Directed bench for grid_update: pickup/drop, chopping, stove timing,
// extinguishing, invalid front cell and reset behaviour.
module tb_grid_update;
    import overcooked_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Clock/reset block
    always #5 clk = ~clk;

    grid_update_if bus();

    grid_update #(
        .CHOP_FRAMES(120),
        .COOK_FRAMES(300),
        .BURN_FRAMES(300),
        .STOVE_X    (6),
        .STOVE_Y    (0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    grid_t exp_grid;

    task automatic check_eq(input string tag, input logic [415:0] got,
                            input logic [415:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_layout();
        exp_grid         = '0;
        exp_grid[0][6]   = G_POT_EMPTY;
        exp_grid[7][0]   = G_ONION_WHOLE;
        exp_grid[7][12]  = G_BOWL_EMPTY;
        exp_grid[0][12]  = G_EXTINGUISHER;
    endtask

    // Driver tasks
    task automatic tick(input logic [3:0] st, input logic [3:0] x, input logic [2:0] y);
        @(negedge clk);
        bus.player_state = st;
        bus.x_front      = x;
        bus.y_front      = y;
        bus.frame_tick   = 1'b1;
        @(negedge clk);
        bus.frame_tick   = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic [3:0] st, input logic [3:0] x,
                         input logic [2:0] y);
        for (int i = 0; i < n; i++) tick(st, x, y);
    endtask

    // Reset is applied together with a tick that would otherwise pick up the onion.
    task automatic apply_reset();
        @(negedge clk);
        reset            = 1'b1;
        bus.frame_tick   = 1'b1;
        bus.player_state = P_ONION_WHOLE;
        bus.x_front      = 4'd0;
        bus.y_front      = 3'd7;
        repeat (2) @(negedge clk);
        reset            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.player_state = P_NOTHING;
        set_layout();
    endtask

    initial begin
        bus.frame_tick   = 1'b0;
        bus.player_state = P_NOTHING;
        bus.x_front      = 4'd0;
        bus.y_front      = 3'd0;

        apply_reset();
        check_eq("reset_grid", bus.object_grid, exp_grid);
        check_eq("reset_chop", bus.chop_count, 10'd0);
        check_eq("reset_cook", bus.cook_count, 10'd0);
        check_eq("reset_stove_state", bus.stove_state, ST_IDLE);

        tick(P_NOTHING, 4'd0, 3'd7);
        check_eq("idle_tick_grid", bus.object_grid, exp_grid);
        tick(P_ONION_WHOLE, 4'd0, 3'd7);
        exp_grid[7][0] = G_EMPTY;
        check_eq("pickup_grid", bus.object_grid, exp_grid);
        tick(P_NOTHING, 4'd3, 3'd4);
        exp_grid[4][3] = G_ONION_WHOLE;
        check_eq("drop_grid", bus.object_grid, exp_grid);

        tick(P_NOTHING, 4'd12, 3'd7);
        tick(P_BOWL_EMPTY, 4'd12, 3'd7);
        exp_grid[7][12] = G_EMPTY;
        check_eq("bowl_pickup_grid", bus.object_grid, exp_grid);
        tick(P_NOTHING, 4'd3, 3'd4);
        check_eq("drop_occupied_cell", bus.object_grid[4][3], G_ONION_WHOLE);
        check_eq("drop_occupied_grid", bus.object_grid, exp_grid);

        ticks(50, P_CHOPPING, 4'd3, 3'd4);
        check_eq("chop_50", bus.chop_count, 10'd50);
        tick(P_CHOPPING, 4'd4, 3'd4);
        check_eq("chop_moved_away", bus.chop_count, 10'd0);
        tick(P_CHOPPING, 4'd3, 3'd4);
        check_eq("chop_moved_back", bus.chop_count, 10'd0);
        ticks(119, P_CHOPPING, 4'd3, 3'd4);
        check_eq("chop_119", bus.chop_count, 10'd119);
        check_eq("chop_119_cell", bus.object_grid[4][3], G_ONION_WHOLE);
        tick(P_CHOPPING, 4'd3, 3'd4);
        exp_grid[4][3] = G_ONION_CHOPPED;
        check_eq("chop_done_grid", bus.object_grid, exp_grid);
        check_eq("chop_done_count", bus.chop_count, 10'd0);

        tick(P_NOTHING, 4'd6, 3'd0);
        tick(P_POT_EMPTY, 4'd6, 3'd0);
        exp_grid[0][6] = G_EMPTY;
        tick(P_POT_RAW, 4'd3, 3'd4);
        exp_grid[4][3] = G_EMPTY;
        tick(P_NOTHING, 4'd6, 3'd0);
        exp_grid[0][6] = G_POT_RAW;
        check_eq("raw_pot_placed_grid", bus.object_grid, exp_grid);
        check_eq("raw_pot_placed_cook", bus.cook_count, 10'd0);

        ticks(299, P_NOTHING, 4'd6, 3'd0);
        check_eq("cook_299", bus.cook_count, 10'd299);
        check_eq("cook_299_cell", bus.object_grid[0][6], G_POT_RAW);
        check_eq("cook_299_state", bus.stove_state, ST_COOKING);
        tick(P_NOTHING, 4'd6, 3'd0);
        exp_grid[0][6] = G_POT_COOKED;
        check_eq("cooked_grid", bus.object_grid, exp_grid);
        check_eq("cooked_count", bus.cook_count, 10'd0);
        ticks(299, P_NOTHING, 4'd6, 3'd0);
        check_eq("burn_299", bus.cook_count, 10'd299);
        check_eq("burn_299_state", bus.stove_state, ST_BURNING);
        tick(P_NOTHING, 4'd6, 3'd0);
        exp_grid[0][6] = G_POT_FIRE;
        check_eq("fire_grid", bus.object_grid, exp_grid);
        check_eq("fire_count", bus.cook_count, 10'd0);
        ticks(5, P_NOTHING, 4'd6, 3'd0);
        check_eq("fire_idle_count", bus.cook_count, 10'd0);
        check_eq("fire_idle_state", bus.stove_state, ST_IDLE);

        tick(P_EXT_OFF, 4'd12, 3'd0);
        exp_grid[0][12] = G_EMPTY;
        tick(P_EXT_ON, 4'd6, 3'd0);
        exp_grid[0][6] = G_POT_EMPTY;
        check_eq("extinguish_cell", bus.object_grid[0][6], G_POT_EMPTY);
        check_eq("extinguish_grid", bus.object_grid, exp_grid);
        check_eq("extinguish_cook", bus.cook_count, 10'd0);

        apply_reset();
        check_eq("reset2_grid", bus.object_grid, exp_grid);
        tick(P_NOTHING, 4'd13, 3'd7);
        tick(P_ONION_WHOLE, 4'd13, 3'd7);
        check_eq("pickup_x13_grid", bus.object_grid, exp_grid);
        tick(P_NOTHING, 4'd13, 3'd7);
        check_eq("drop_x13_grid", bus.object_grid, exp_grid);

        tick(P_NOTHING, 4'd0, 3'd7);
        ticks(120, P_CHOPPING, 4'd0, 3'd7);
        exp_grid[7][0] = G_ONION_CHOPPED;
        check_eq("chop_in_place_grid", bus.object_grid, exp_grid);
        tick(P_NOTHING, 4'd6, 3'd0);
        tick(P_POT_EMPTY, 4'd6, 3'd0);
        exp_grid[0][6] = G_EMPTY;
        tick(P_POT_RAW, 4'd0, 3'd7);
        exp_grid[7][0] = G_EMPTY;
        tick(P_NOTHING, 4'd6, 3'd0);
        exp_grid[0][6] = G_POT_RAW;
        ticks(150, P_NOTHING, 4'd6, 3'd0);
        check_eq("cook_150_grid", bus.object_grid, exp_grid);
        check_eq("cook_150", bus.cook_count, 10'd150);

        apply_reset();
        check_eq("reset_mid_grid", bus.object_grid, exp_grid);
        check_eq("reset_mid_chop", bus.chop_count, 10'd0);
        check_eq("reset_mid_cook", bus.cook_count, 10'd0);
        check_eq("reset_mid_state", bus.stove_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_update.md
# grid_update

Maintains the 8×13 kitchen object grid and applies every grid change caused by player actions and stove cooking. It sits directly downstream of the player-state machine. Once per frame it compares the player state it is given with the state from the previous frame and the object in the cell in front of the player, then writes the result back into `object_grid`. That grid feeds the player-state logic, the renderer and the scorer.

## Interface
Parameters:
- `CHOP_FRAMES`, 120: frames of continuous chopping needed to turn a whole onion into a chopped one.
- `COOK_FRAMES`, 300: frames a raw pot must sit on the stove to become cooked.
- `BURN_FRAMES`, 300: frames a cooked pot may stay on the stove before it catches fire.
- `STOVE_X`, 6 and `STOVE_Y`, 0: grid cell of the stove.

Ports (clock and reset first):
- `clk` input 1: system clock.
- `reset` input 1: reset, synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse per frame, asserted after the player-state update has settled.
- `player_state` input 4: current P_* code.
- `x_front` input 4: column of the cell in front of the player.
- `y_front` input 3: row of the cell in front of the player.
- `object_grid` output [7:0][12:0][3:0]: G_* code per cell, indexed [y][x].
- `chop_count` output 10: chopping progress, 0 to CHOP_FRAMES-1.
- `cook_count` output 10: stove timer, 0 to max(COOK,BURN)-1.

## Operation
- All updates happen only in the clk cycle where `frame_tick`=1. On every tick, `prev_state` is loaded with `player_state`.
- Front cell is valid only when `x_front`≤12; otherwise no player-driven write occurs. All 3-bit `y_front` values are in range.
- Pickup: `prev_state`=P_NOTHING and the current state is a carry state (P_ONION_WHOLE through P_EXT_OFF). The front cell is written G_EMPTY.
- Drop: `prev_state` is a carry state and the current state is P_NOTHING. The front cell is written with the grid code for `prev_state` (ONION_WHOLE→1, ONION_CHOPPED→2, POT_EMPTY→5, POT_RAW→6, POT_COOKED→7, BOWL_EMPTY→3, BOWL_FULL→4, EXT_OFF→10). The write happens only if the front cell is G_EMPTY; otherwise the object is lost and the grid is unchanged.
- P_POT_EMPTY→P_POT_RAW: front G_ONION_CHOPPED is written G_EMPTY.
- P_POT_COOKED→P_POT_EMPTY: front G_BOWL_EMPTY is written G_BOWL_FULL.
- P_BOWL_EMPTY→P_BOWL_FULL: front G_POT_COOKED is written G_POT_EMPTY.
- Chopping: while the state is P_CHOPPING and the front cell is G_ONION_WHOLE, `chop_count` increments each tick. On the tick where it would reach CHOP_FRAMES, the front cell is written G_ONION_CHOPPED and `chop_count` returns to 0. `chop_count` also clears on any tick where the state is not P_CHOPPING, the front cell is not G_ONION_WHOLE, or (`x_front`,`y_front`) differs from the previous tick.
- Extinguish: the state is P_EXT_ON and the front cell is G_FIRE → written G_EMPTY; front G_POT_FIRE → written G_POT_EMPTY.
- Stove timer states:
  - IDLE: stove cell not 6 or 7; `cook_count`=0.
  - COOKING: stove cell = G_POT_RAW; the count increments, and at COOK_FRAMES the stove is written G_POT_COOKED and the count returns to 0.
  - BURNING: stove cell = G_POT_COOKED; the count increments, and at BURN_FRAMES the stove is written G_POT_FIRE and the count returns to 0.
  - The state follows the stove cell contents each tick.
- Simultaneous player write and timer write to the stove cell: the player write wins and `cook_count` clears.
- Reset state:
  - All cells G_EMPTY except the layout cells: [0][STOVE_X]=G_POT_EMPTY, [7][0]=G_ONION_WHOLE, [7][12]=G_BOWL_EMPTY, [0][12]=G_EXTINGUISHER.
  - `prev_state`=P_NOTHING, and both counts are 0.

## Timing
- Latency: the grid and counts update on the clk edge ending the `frame_tick` cycle. The outputs hold between ticks.
- At most one player-driven write and one stove write per tick.
- Reset takes priority over `frame_tick`. Reset asserted mid-count discards all progress, and outputs hold their reset values on the next edge.
- Counters saturate only by wrap-to-0 at their limits. They never exceed the limit minus 1.

## Structure
- Shared package `overcooked_pkg` holds:
  - the P_* and G_* constants;
  - the grid dimensions (8, 13);
  - function `state_to_grid(P_*) → G_*`, which returns G_EMPTY for non-carry states.
- Sub-module `cook_timer`: holds the stove FSM and counter. Its inputs are the stove cell code, `frame_tick` and `player_wrote_stove`. Its outputs are `stove_write_en`, `stove_write_val` and `cook_count`.

## Test plan
- Pickup and drop:
  - Reset, state NOTHING with front (0,7), then one tick with state P_ONION_WHOLE → grid[7][0]=0.
  - Move front to (3,4) and tick with state P_NOTHING → grid[4][3]=1.
- Chopping:
  - Whole onion at the front cell, P_CHOPPING held for 119 ticks → `chop_count`=119 and the cell is still 1. Tick 120 → the cell is 2 and `chop_count`=0.
  - Change `x_front` mid-chop → `chop_count`=0.
- Stove timing: place a raw pot (6) on the stove, idle 300 ticks → stove=7. Idle another 300 ticks → stove=8.
- Extinguish: P_EXT_ON with front on a stove at G_POT_FIRE → stove=5 and `cook_count`=0.
- Drop onto an occupied cell: drop P_BOWL_EMPTY onto a cell holding 1 → the cell stays 1.
- Reset mid-operation: reset at `cook_count`=150 → the full layout is restored and both counts are 0. Also check `x_front`=13 on a pickup → no grid change.
